lsu_mem_master: RTL and testbench

// - Load/store initiator between the MEM pipeline stage and the word-addressed data memory.
// - Turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into 32-bit word transactions on a req/gnt/rvalid bus.
// - Does sub-word stores as read-modify-write and sign/zero-extends load results.
// - Holds busy_o high while a transaction runs; hazard logic stalls the pipeline on it.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_mem_master_lane_align.sv | 34 +++
 rtl/lsu_mem_master.sv | 136 +++++++++++++
 tb/tb_lsu_mem_master.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store master: funct3 codes, FSM states
// and lane-select helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_DONE
  } lsu_state_e;

  // Size comes from funct3[1:0]; the undefined codes 011/110/111 all land on word.
  function automatic logic is_byte(input logic [2:0] f3);
    return f3[1:0] == 2'b00;
  endfunction

  function automatic logic is_half(input logic [2:0] f3);
    return f3[1:0] == 2'b01;
  endfunction

  function automatic logic is_word(input logic [2:0] f3);
    return !is_byte(f3) && !is_half(f3);
  endfunction

  // Byte offset with the low bits forced to the natural alignment of the access.
  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
    if (is_byte(f3)) return off;
    if (is_half(f3)) return {off[1], 1'b0};
    return 2'b00;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    if (is_half(f3)) return off[0];
    if (is_word(f3)) return off != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/lsu_mem_master_lane_align.sv
// Combinational lane logic: extract + sign/zero-extend for loads, and
// single-lane merge of store data into a read word for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  b;
  logic [15:0] h;

  // Select the addressed lane, extend it, and build the merged store word.
  always_comb begin
    b       = rdata_i[{off_i, 3'b000} +: 8];
    h       = rdata_i[{off_i[1], 4'b0000} +: 16];
    load_o  = rdata_i;
    merge_o = wdata_i;
    if (is_byte(funct3_i)) begin
      load_o  = funct3_i[2] ? {24'b0, b} : {{24{b[7]}}, b};
      merge_o = rdata_i;
      merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
    end else if (is_half(funct3_i)) begin
      load_o  = funct3_i[2] ? {16'b0, h} : {{16{h[15]}}, h};
      merge_o = rdata_i;
      merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
    end
  end

endmodule

// File: rtl/lsu_mem_master.sv
// RV32I load/store master onto a word-addressed req/gnt/rvalid memory bus.
// Sub-word stores are read-modify-write. Optional macro LSU_MISALIGN_TRAP_EN
// rejects misaligned H/W requests instead of silently aligning them.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_valid_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_funct3_i,
  input  logic [31:0]       lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              misalign_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  lsu_state_e        state_q, state_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  logic [31:0]       wr_q, ld_q;
  logic [31:0]       load_ext, merged;
  logic              accept, reject;

  // Upper address bits wrap away by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^lsu_addr_i[31:ADDR_W+2];

  // Request acceptance; a misaligned request is dropped when trapping is built in.
  always_comb begin
    reject = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    reject = misaligned(lsu_funct3_i, lsu_addr_i[1:0]);
`endif
    accept = (state_q == S_IDLE) && lsu_valid_i && !reject;
  end

  lsu_lane_align u_align (
    .funct3_i (f3_q),
    .off_i    (off_q),
    .rdata_i  (mem_rdata_i),
    .wdata_i  (wr_q),
    .load_o   (load_ext),
    .merge_o  (merged)
  );

  // State register; async reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept)
                   state_d = (lsu_we_i && is_word(lsu_funct3_i)) ? S_WR_REQ : S_RD_REQ;
      S_RD_REQ:  if (mem_gnt_i)    state_d = S_RD_WAIT;
      S_RD_WAIT: if (mem_rvalid_i) state_d = we_q ? S_WR_REQ : S_DONE;
      S_WR_REQ:  if (mem_gnt_i)    state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Bus and handshake outputs decoded from the state.
  always_comb begin
    busy_o    = 1'b0;
    done_o    = 1'b0;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    case (state_q)
      S_RD_REQ:  begin busy_o = 1'b1; mem_req_o = 1'b1; end
      S_RD_WAIT: busy_o = 1'b1;
      S_WR_REQ:  begin busy_o = 1'b1; mem_req_o = 1'b1; mem_we_o = 1'b1; end
      S_DONE:    done_o = 1'b1;
      default:   ;
    endcase
  end

  // Input latches, merged store word and captured load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      f3_q   <= 3'b000;
      addr_q <= '0;
      off_q  <= 2'b00;
      wr_q   <= '0;
      ld_q   <= '0;
    end else begin
      if (accept) begin
        we_q   <= lsu_we_i;
        f3_q   <= lsu_funct3_i;
        addr_q <= lsu_addr_i[ADDR_W+1:2];
        off_q  <= align_off(lsu_funct3_i, lsu_addr_i[1:0]);
        wr_q   <= lsu_wdata_i;
      end
      if (state_q == S_RD_WAIT && mem_rvalid_i) begin
        if (we_q) wr_q <= merged;
        else      ld_q <= load_ext;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;
  // One-cycle pulse per rejected request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= (state_q == S_IDLE) && lsu_valid_i && reject;
  end
  assign misalign_o = mis_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign load_data_o = ld_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wr_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a small req/gnt/rvalid memory model.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic        lsu_valid = 1'b0, lsu_we = 1'b0;
  logic [2:0]  lsu_f3 = 3'b000;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic        busy, done, misalign, mem_req, mem_we, mem_gnt;
  logic [31:0] load_data, mem_wdata;
  logic [7:0]  mem_addr;
  logic        rvalid_q = 1'b0;
  logic [31:0] rdata_q = '0;

  int tests = 0, fails = 0;

  // memory model state
  logic [31:0] mem [256];
  int          stall_len = 0, req_cyc = 0, wr_cnt = 0, rd_cnt = 0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid_i(lsu_valid), .lsu_we_i(lsu_we), .lsu_funct3_i(lsu_f3),
    .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .busy_o(busy), .done_o(done), .load_data_o(load_data), .misalign_o(misalign),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(rvalid_q), .mem_rdata_i(rdata_q)
  );

  // Grant after stall_len cycles of request; read data one cycle after read grant.
  assign mem_gnt = mem_req && (req_cyc >= stall_len);

  always @(posedge clk) begin
    req_cyc  <= (!mem_req || mem_gnt) ? 0 : req_cyc + 1;
    rvalid_q <= mem_req && mem_gnt && !mem_we;
    if (mem_req && mem_gnt && !mem_we) begin
      rdata_q <= mem[mem_addr];
      rd_cnt  <= rd_cnt + 1;
    end
    if (mem_req && mem_gnt && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
    end
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One request; lat = cycles from accept cycle to done_o (40 = timed out).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat);
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = we; lsu_f3 = f3; lsu_addr = addr; lsu_wdata = wd;
    @(negedge clk);
    lsu_valid = 1'b0; lsu_we = ~we; lsu_f3 = 3'b111;
    lsu_addr = 32'hFFFF_FFFF; lsu_wdata = 32'h5A5A_5A5A;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({busy, done, misalign, mem_req, mem_we} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl got %b exp 00000", {busy, done, misalign, mem_req, mem_we});
    end
    tests++;
    if (mem_addr !== 8'h00 || mem_wdata !== 32'h0 || load_data !== 32'h0) begin
      fails++; $display("FAIL reset_data got %h/%h/%h exp zeros", mem_addr, mem_wdata, load_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [6] = '{F3_LB, F3_LHU, F3_LH, F3_LBU, F3_LW, F3_LB};
    logic [31:0] ad  [6] = '{32'h16, 32'h14, 32'h16, 32'h17, 32'h14, 32'h14};
    logic [31:0] exp [6] = '{32'hFFFF_FF99, 32'h0000_AABB, 32'hFFFF_8899,
                             32'h0000_0088, 32'h8899_AABB, 32'hFFFF_FFBB};
    int lat;
    preload(8'd5, 32'h8899_AABB);
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, f3[i], ad[i], 32'h0, lat);
      tests++;
      if (load_data !== exp[i] || lat != 3) begin
        fails++; $display("FAIL load%0d got %h lat %0d exp %h lat 3", i, load_data, lat, exp[i]);
      end
    end
    @(negedge clk);
    tests++;
    if (load_data !== 32'hFFFF_FFBB || done !== 1'b0) begin
      fails++; $display("FAIL load_hold got %h done %b exp ffffffbb done 0", load_data, done);
    end
  endtask

  task automatic test_substore();
    int lat, w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    issue(1'b1, F3_LB, 32'h15, 32'h0000_0042, lat);
    tests++;
    if (mem[5] !== 32'h8899_42BB || lat != 4 || wr_cnt - w0 != 1 || rd_cnt - r0 != 1) begin
      fails++; $display("FAIL sb got %h lat %0d wr %0d rd %0d exp 889942bb lat 4 wr 1 rd 1",
                        mem[5], lat, wr_cnt - w0, rd_cnt - r0);
    end
    issue(1'b1, F3_LH, 32'h16, 32'hAAAA_1234, lat);
    tests++;
    if (mem[5] !== 32'h1234_42BB || lat != 4) begin
      fails++; $display("FAIL sh got %h lat %0d exp 123442bb lat 4", mem[5], lat);
    end
  endtask

  task automatic test_sw_stall();
    int lat;
    issue(1'b1, F3_LW, 32'h40, 32'h0BAD_F00D, lat);
    tests++;
    if (mem[16] !== 32'h0BAD_F00D || lat != 2) begin
      fails++; $display("FAIL sw got %h lat %0d exp 0badf00d lat 2", mem[16], lat);
    end
    stall_len = 3;
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b1; lsu_f3 = F3_LW; lsu_addr = 32'h20; lsu_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    lsu_valid = 1'b0; lsu_addr = 32'h44; lsu_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, done} !== {1'b1, 1'b1, 8'h08, 32'hDEAD_BEEF, 1'b0}) begin
        fails++; $display("FAIL sw_stall%0d got req %b we %b a %h d %h done %b exp 1 1 08 deadbeef 0",
                          i, mem_req, mem_we, mem_addr, mem_wdata, done);
      end
      @(negedge clk);
    end
    tests++;
    if (done !== 1'b1 || mem[8] !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL sw_stall_done got done %b mem %h exp 1 deadbeef", done, mem[8]);
    end
    stall_len = 0;
  endtask

  task automatic test_reset_abort();
    int w0, r0;
    preload(8'd6, 32'h1122_3344);
    // reset while a read request is stalled
    stall_len = 5;
    r0 = rd_cnt;
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_f3 = F3_LW; lsu_addr = 32'h18;
    @(negedge clk);
    lsu_valid = 1'b0;
    rst = 1'b1; #1;
    tests++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_rdreq got req %b busy %b exp 0 0", mem_req, busy);
    end
    @(negedge clk); rst = 1'b0; stall_len = 0;
    // reset in RD_WAIT of an SH
    w0 = wr_cnt;
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b1; lsu_f3 = F3_LH; lsu_addr = 32'h18; lsu_wdata = 32'h0000_BEEF;
    @(negedge clk);
    lsu_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || mem_req !== 1'b0) begin
      fails++; $display("FAIL sh_rdwait got busy %b req %b exp 1 0", busy, mem_req);
    end
    rst = 1'b1; #1;
    tests++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || mem_addr !== 8'h00) begin
      fails++; $display("FAIL rst_rdwait got req %b busy %b a %h exp 0 0 00", mem_req, busy, mem_addr);
    end
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (wr_cnt != w0 || mem[6] !== 32'h1122_3344 || rd_cnt - r0 != 1 || done !== 1'b0) begin
      fails++; $display("FAIL rst_nowrite got wr %0d rd %0d mem %h exp wr 0 rd 1 mem 11223344",
                        wr_cnt - w0, rd_cnt - r0, mem[6]);
    end
  endtask

  task automatic test_misalign_wrap();
    int lat;
    preload(8'd4, 32'hCAFE_F00D);
`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_f3 = F3_LW; lsu_addr = 32'h13;
    @(negedge clk);
    lsu_valid = 1'b0;
    tests++;
    if (misalign !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL mis_pulse got mis %b req %b busy %b exp 1 0 0", misalign, mem_req, busy);
    end
    @(negedge clk);
    tests++;
    if (misalign !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL mis_after got mis %b req %b busy %b done %b exp 0", misalign, mem_req, busy, done);
    end
`else
    issue(1'b0, F3_LW, 32'h13, 32'h0, lat);
    tests++;
    if (load_data !== 32'hCAFE_F00D || lat != 3 || misalign !== 1'b0) begin
      fails++; $display("FAIL lw_unaligned got %h lat %0d exp cafef00d lat 3", load_data, lat);
    end
    issue(1'b0, F3_LH, 32'h17, 32'h0, lat);
    tests++;
    if (load_data !== 32'h0000_1234) begin
      fails++; $display("FAIL lh_unaligned got %h exp 00001234", load_data);
    end
`endif
    // address wrap: 0x414 -> word 5; undefined funct3 acts as word
    issue(1'b0, F3_LW, 32'h0000_0414, 32'h0, lat);
    tests++;
    if (load_data !== 32'h1234_42BB) begin
      fails++; $display("FAIL wrap got %h exp 123442bb", load_data);
    end
    issue(1'b0, 3'b011, 32'h16, 32'h0, lat);
    tests++;
    if (load_data !== 32'h1234_42BB || lat != 3) begin
      fails++; $display("FAIL f3_undef got %h lat %0d exp 123442bb lat 3", load_data, lat);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_substore();
    test_sw_stall();
    test_reset_abort();
    test_misalign_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
